// File: rtl/tile_map_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tile_map_ctrl
// Purpose  : COLS x ROWS playfield tile store.
//            - Loads preset maps from an internal ROM.
//            - Provides two combinational read ports (drawing and collision).
//            - Keeps an incremental gift count and raises a level-clear pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tile_map_ctrl #(
  parameter int COLS      = 8,
  parameter int ROWS      = 6,
  parameter int TW        = 2,
  parameter int NUM_MAPS  = 4,
  parameter int GIFT_CODE = 2,
  parameter int EXIT_CODE = 3,
  parameter int EXIT_X    = 0,
  parameter int EXIT_Y    = ROWS - 1,
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS),
  localparam int MW = $clog2(NUM_MAPS),
  localparam int CW = $clog2(COLS * ROWS + 1)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          load_req,
  input  logic [MW-1:0] map_sel,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [TW-1:0] wr_data,
  input  logic [XW-1:0] rd_a_x,
  input  logic [YW-1:0] rd_a_y,
  output logic [TW-1:0] rd_a_data,
  input  logic [XW-1:0] rd_b_x,
  input  logic [YW-1:0] rd_b_y,
  output logic [TW-1:0] rd_b_data,
  output logic          busy,
  output logic          wr_ack,
  output logic [CW-1:0] gift_count,
  output logic          level_clear
);

  localparam int CELLS    = COLS * ROWS;
  localparam int IW       = $clog2(CELLS);
  localparam int EXIT_IDX = EXIT_Y * COLS + EXIT_X;
  localparam logic [TW-1:0] GIFT = TW'(GIFT_CODE);
  localparam logic [TW-1:0] EXIT = TW'(EXIT_CODE);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Preset map table.
  // Map 0: floor row, 2 gifts.
  // Map 1: floor row, 3 gifts.
  // Map 2: floor row, no gifts.
  // Map 3: floor row, a full top row of gifts.
  function automatic logic [TW-1:0] rom_tile(input int map, input int x, input int y);
    logic [TW-1:0] t;
    t = '0;
    case (map)
      1: begin
        if (y == ROWS - 1) t = TW'(1);
        if ((x == 0 && y == 0) || (x == COLS - 1 && y == 0) ||
            (x == COLS / 2 && y == ROWS / 2)) t = GIFT;
      end
      2: begin
        if (y == ROWS - 1) t = TW'(1);
      end
      3: begin
        if (y == ROWS - 1) t = TW'(1);
        if (y == 0) t = GIFT;
      end
      default: begin
        if (y == ROWS - 1) t = TW'(1);
        if ((x == 1 && y == ROWS - 1) || (x == COLS - 2 && y == ROWS - 2)) t = GIFT;
      end
    endcase
    return t;
  endfunction

  function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (int'(x) < COLS) && (int'(y) < ROWS);
  endfunction

  function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    int i;
    i = int'(y) * COLS + int'(x);
    return IW'(i);
  endfunction

  logic [TW-1:0] grid [CELLS];
  state_t        state;
  logic [IW-1:0] scan_idx;
  logic [MW-1:0] map_lat;
  logic          cleared;

  logic [IW-1:0] wr_idx;
  logic          wr_accept;
  logic          clear_fire;
  logic [TW-1:0] old_tile;
  logic [TW-1:0] new_tile;
  logic          count_inc;
  logic          count_dec;

  // Write qualification, level-clear trigger and gift-count delta.
  // The effective new tile accounts for the exit overwrite winning over a user write.
  always_comb begin
    wr_idx     = cell_idx(wr_x, wr_y);
    wr_accept  = (state == RUN) && wr_en && !load_req && in_range(wr_x, wr_y);
    clear_fire = (state == RUN) && !load_req && (gift_count == '0) && !cleared;
    old_tile   = wr_accept ? grid[wr_idx] : '0;
    new_tile   = (clear_fire && (wr_idx == IW'(EXIT_IDX))) ? EXIT : wr_data;
    count_inc  = wr_accept && (old_tile != GIFT) && (new_tile == GIFT) && (gift_count != '1);
    count_dec  = wr_accept && (old_tile == GIFT) && (new_tile != GIFT) && (gift_count != '0);
  end

  // Combinational read ports; out-of-range coordinates read as empty.
  always_comb begin
    rd_a_data = in_range(rd_a_x, rd_a_y) ? grid[cell_idx(rd_a_x, rd_a_y)] : '0;
    rd_b_data = in_range(rd_b_x, rd_b_y) ? grid[cell_idx(rd_b_x, rd_b_y)] : '0;
  end

  // Grid storage: reset to map 0, bulk copy on LOAD, user and exit-cell writes in RUN.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < CELLS; i++) grid[i] <= rom_tile(0, i % COLS, i / COLS);
    end else if (state == LOAD) begin
      for (int i = 0; i < CELLS; i++) grid[i] <= rom_tile(int'(map_lat), i % COLS, i / COLS);
    end else begin
      if (wr_accept)  grid[wr_idx] <= wr_data;
      // Placed last so the exit code wins over a same-edge user write.
      if (clear_fire) grid[EXIT_IDX] <= EXIT;
    end
  end

  // Control FSM: load / scan / run sequencing, gift counting and registered status outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= SCAN;
      scan_idx    <= '0;
      map_lat     <= '0;
      gift_count  <= '0;
      cleared     <= 1'b0;
      busy        <= 1'b1;
      wr_ack      <= 1'b0;
      level_clear <= 1'b0;
    end else begin
      wr_ack      <= wr_accept;
      level_clear <= clear_fire;
      if (load_req) begin
        // Out-of-table indices fall back to map 0.
        map_lat <= (int'(map_sel) >= NUM_MAPS) ? '0 : map_sel;
        state   <= LOAD;
        busy    <= 1'b1;
      end else begin
        case (state)
          LOAD: begin
            gift_count <= '0;
            cleared    <= 1'b0;
            scan_idx   <= '0;
            state      <= SCAN;
          end
          SCAN: begin
            if ((grid[scan_idx] == GIFT) && (gift_count != '1)) gift_count <= gift_count + 1'b1;
            if (scan_idx == IW'(CELLS - 1)) begin
              scan_idx <= '0;
              state    <= RUN;
              busy     <= 1'b0;
            end else begin
              scan_idx <= scan_idx + 1'b1;
            end
          end
          RUN: begin
            if (clear_fire) cleared <= 1'b1;
            if (count_inc)      gift_count <= gift_count + 1'b1;
            else if (count_dec) gift_count <= gift_count - 1'b1;
          end
          default: begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
